// File: rtl/spi_bus_ctrl.sv
// SPI frame transaction controller: turns data-path strobes into single-word
// register-bus reads/writes with burst prefetch, a bus timeout and sticky errors.
module spi_bus_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              address_ready,
  input  logic              status_ready,
  input  logic              data_ready,
  input  logic              miso_start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        status,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_late,
  output logic              err_cmd,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE, CMD, RD_REQ, RD_HOLD, WR_WAIT, WR_REQ, DRAIN, ABORT
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_t            state, state_d;
  logic [DATA_W-1:0] rdata_d, wdata_d;
  logic [ADDR_W-1:0] addr_d;
  logic              we_d, inc, inc_d, cs_n_q;
  logic              err_t_d, err_l_d, err_c_d;
  logic [CW-1:0]     tmo_cnt;
  logic              ack, tmo;
  logic              status_unused;

  assign status_unused = status[3];
  assign state_dbg     = state;

  // Bus handshake: bus_req is held with stable we/addr/wdata until a one-cycle
  // bus_ack; an ack seen while bus_req is low is ignored.
  assign ack = bus_req & bus_ack;
  assign tmo = bus_req & (tmo_cnt == TMO_LAST);

  always_comb begin
    state_d = state;
    rdata_d = rdata;
    addr_d  = bus_addr;
    wdata_d = bus_wdata;
    we_d    = bus_we;
    inc_d   = inc;
    err_t_d = err_timeout;
    err_l_d = err_late;
    err_c_d = err_cmd;
    if (bus_req && (cs_n || state == DRAIN)) begin
      // Frame ended with an access in flight: keep req until it resolves.
      if (ack) begin
        state_d = IDLE;
      end else if (tmo) begin
        state_d = IDLE;
        err_t_d = 1'b1;
      end else begin
        state_d = DRAIN;
      end
    end else if (cs_n) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (cs_n_q) begin
            err_t_d = 1'b0;
            err_l_d = 1'b0;
            err_c_d = 1'b0;
          end
          if (address_ready) begin
            addr_d  = addr;
            state_d = CMD;
          end
        end
        CMD: begin
          if (status_ready) begin
            inc_d = status[0];
            unique case (status[2:1])
              2'b01: begin state_d = RD_REQ; we_d = 1'b0; end
              2'b10: state_d = WR_WAIT;
              2'b11: begin state_d = ABORT; err_c_d = 1'b1; end
              default: state_d = IDLE;
            endcase
          end
        end
        RD_REQ: begin
          // The data path started shifting before the word arrived.
          if (miso_start) err_l_d = 1'b1;
          if (ack) begin
            rdata_d = bus_rdata;
            state_d = RD_HOLD;
          end else if (tmo) begin
            err_t_d = 1'b1;
            state_d = ABORT;
          end
        end
        RD_HOLD: begin
          if (miso_start) begin
            if (inc) addr_d = bus_addr + ADDR_W'(1);
            we_d    = 1'b0;
            state_d = RD_REQ;
          end
        end
        WR_WAIT: begin
          if (data_ready) begin
            wdata_d = wdata;
            we_d    = 1'b1;
            state_d = WR_REQ;
          end
        end
        WR_REQ: begin
          if (ack) begin
            state_d = IDLE;
          end else if (tmo) begin
            err_t_d = 1'b1;
            state_d = ABORT;
          end
        end
        ABORT:   state_d = ABORT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rdata       <= '0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      err_late    <= 1'b0;
      err_cmd     <= 1'b0;
      inc         <= 1'b0;
      cs_n_q      <= 1'b1;
      tmo_cnt     <= '0;
    end else begin
      state       <= state_d;
      rdata       <= rdata_d;
      bus_addr    <= addr_d;
      bus_wdata   <= wdata_d;
      bus_we      <= we_d;
      bus_req     <= (state_d == RD_REQ) || (state_d == WR_REQ) || (state_d == DRAIN);
      busy        <= (state_d != IDLE);
      err_timeout <= err_t_d;
      err_late    <= err_l_d;
      err_cmd     <= err_c_d;
      inc         <= inc_d;
      cs_n_q      <= cs_n;
      tmo_cnt     <= bus_req ? tmo_cnt + CW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_spi_bus_ctrl.sv
// Bench for spi_bus_ctrl: bus slave with random latency, request scoreboard,
// per-cycle output checks against a transaction-level model, directed + random frames.
module tb_spi_bus_ctrl;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 64;
  localparam int RW      = 1 + ADDR_W + DATA_W;

  logic clk = 1'b0, reset = 1'b1, cs_n = 1'b1;
  logic address_ready = 1'b0, status_ready = 1'b0, data_ready = 1'b0, miso_start = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [3:0]        status = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata, bus_wdata;
  logic [DATA_W-1:0] bus_rdata = '0;
  logic              bus_req, bus_we, busy, err_timeout, err_late, err_cmd;
  logic              bus_ack = 1'b0;
  logic [ADDR_W-1:0] bus_addr;
  logic [2:0]        state_dbg;

  spi_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .address_ready(address_ready),
    .status_ready(status_ready), .data_ready(data_ready), .miso_start(miso_start),
    .addr(addr), .status(status), .wdata(wdata), .rdata(rdata), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .busy(busy), .err_timeout(err_timeout), .err_late(err_late),
    .err_cmd(err_cmd), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // model state
  logic [RW-1:0]     exp_q[$];
  logic [DATA_W-1:0] rsp_q[$];
  logic [DATA_W-1:0] exp_rdata = '0;
  logic              exp_et = 1'b0, exp_el = 1'b0, exp_ec = 1'b0;
  int                ack_lat = 0;
  int                acks = 0;
  int                reqs = 0;
  bit                chk_en = 1'b0;

  // bus slave: acks ack_lat cycles after a request starts (-1 = never)
  int                s_cnt = 0;
  bit                s_active = 1'b0, s_acked = 1'b0, s_ack_out = 1'b0, s_we = 1'b0;
  logic [DATA_W-1:0] s_word = '0;
  logic [RW-1:0]     obs;

  always begin
    @(posedge clk);
    if (s_ack_out) begin
      acks++;
      if (!cs_n && !s_we) exp_rdata = s_word;
    end
    #1;
    bus_ack   = 1'b0;
    s_ack_out = 1'b0;
    if (bus_req && !reset) begin
      if (!s_active) begin
        s_active = 1'b1;
        s_acked  = 1'b0;
        s_cnt    = 0;
        s_we     = bus_we;
        reqs++;
        obs = {bus_we, bus_addr, bus_we ? bus_wdata : DATA_W'(0)};
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL req_unexpected: got %0h expected none at %0t", obs, $time);
        end else begin
          check("req", obs, exp_q.pop_front());
        end
      end
      if (ack_lat >= 0 && s_cnt == ack_lat && !s_acked) begin
        if (rsp_q.size() > 0) s_word = rsp_q.pop_front();
        else                  s_word = DATA_W'($urandom);
        bus_rdata = s_word;
        bus_ack   = 1'b1;
        s_ack_out = 1'b1;
        s_acked   = 1'b1;
      end
      s_cnt++;
    end else if (s_active) begin
      s_active = 1'b0;
      if (!s_acked && s_cnt >= TIMEOUT) exp_et = 1'b1;
    end
  end

  // per-cycle compare against the model
  logic              p_req = 1'b0, p_we = 1'b0;
  logic [ADDR_W-1:0] p_addr = '0;
  logic [DATA_W-1:0] p_wdata = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("rdata", rdata, exp_rdata);
      check("err_flags", {err_timeout, err_late, err_cmd}, {exp_et, exp_el, exp_ec});
      if (bus_req && p_req)
        check("req_stable", {bus_we, bus_addr, bus_wdata}, {p_we, p_addr, p_wdata});
    end
    p_req   = bus_req;
    p_we    = bus_we;
    p_addr  = bus_addr;
    p_wdata = bus_wdata;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start(input logic [ADDR_W-1:0] a);
    cs_n = 1'b0;
    addr = a;
    address_ready = 1'b1;
    tick();
    address_ready = 1'b0;
    addr = ADDR_W'($urandom);
    exp_et = 1'b0;
    exp_el = 1'b0;
    exp_ec = 1'b0;
  endtask

  task automatic send_status(input logic [3:0] s);
    status = s;
    status_ready = 1'b1;
    tick();
    status_ready = 1'b0;
    status = 4'($urandom);
  endtask

  task automatic send_data(input logic [DATA_W-1:0] d);
    wdata = d;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    wdata = DATA_W'($urandom);
  endtask

  task automatic pulse_miso();
    miso_start = 1'b1;
    tick();
    miso_start = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    int a0 = acks;
    int n = 0;
    while (acks == a0 && n < 200) begin
      tick();
      n++;
    end
    check(name, (acks != a0), 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic count_req(output int len);
    len = 0;
    while (bus_req && len < 300) begin
      len++;
      tick();
    end
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    tick();
    wait_idle("end_frame_idle");
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;
    int n;
    int rq0;
    bit inc;
    logic [ADDR_W-1:0] base, a;
    logic [DATA_W-1:0] d;

    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", {rdata, bus_addr, bus_wdata}, 0);
    check("reset_ctrl", {bus_req, bus_we, busy, err_timeout, err_late, err_cmd}, 0);
    tick();
    reset = 1'b0;
    chk_en = 1'b1;
    tick();

    // single read
    ack_lat = 3;
    rsp_q.push_back(16'hBEEF);
    exp_q.push_back({1'b0, 20'h12345, 16'h0000});
    frame_start(20'h12345);
    check("rd_addr_latch", bus_addr, 20'h12345);
    send_status(4'b0010);
    check("rd_req_rise", {bus_req, bus_we}, 2'b10);
    wait_ack("rd_ack");
    check("rd_rdata", rdata, 16'hBEEF);
    check("rd_req_low", bus_req, 0);
    end_frame();

    // single write
    ack_lat = 1;
    exp_q.push_back({1'b1, 20'h00010, 16'hA5A5});
    frame_start(20'h00010);
    send_status(4'b0100);
    check("wr_wait_noreq", bus_req, 0);
    send_data(16'hA5A5);
    check("wr_req_rise", {bus_req, bus_we, bus_wdata}, {2'b11, 16'hA5A5});
    count_req(len);
    check("wr_req_len", len, 2);
    check("wr_idle", busy, 0);
    end_frame();

    // burst with increment across the address wrap
    ack_lat = $urandom_range(0, 4);
    base = 20'hFFFFE;
    for (int i = 0; i < 4; i++) begin
      a = base + ADDR_W'(i);
      exp_q.push_back({1'b0, a, DATA_W'(0)});
    end
    frame_start(base);
    send_status(4'b0011);
    for (int i = 0; i < 4; i++) begin
      wait_ack("burst_ack");
      if (i < 3) pulse_miso();
    end
    check("burst_wrap_addr", bus_addr, 20'h00001);
    end_frame();

    // timeout
    ack_lat = -1;
    exp_q.push_back({1'b0, 20'h0ABCD, 16'h0000});
    frame_start(20'h0ABCD);
    send_status(4'b0010);
    count_req(len);
    check("tmo_req_len", len, TIMEOUT);
    check("tmo_flag", err_timeout, 1);
    repeat (5) tick();
    check("abort_busy", {busy, bus_req}, 2'b10);
    end_frame();
    frame_start(20'h00001);
    check("tmo_flag_cleared", err_timeout, 0);
    send_status(4'b0000);
    check("nop_idle", {busy, bus_req}, 2'b00);
    end_frame();

    // ack in the very cycle the timeout would fire
    ack_lat = TIMEOUT - 1;
    rsp_q.push_back(16'h1234);
    exp_q.push_back({1'b0, 20'h00200, 16'h0000});
    frame_start(20'h00200);
    send_status(4'b0010);
    count_req(len);
    check("edge_req_len", len, TIMEOUT);
    check("edge_no_tmo", err_timeout, 0);
    check("edge_rdata", rdata, 16'h1234);
    end_frame();

    // deselect while a read is pending
    ack_lat = 8;
    rsp_q.push_back(16'h7777);
    exp_q.push_back({1'b0, 20'h00400, 16'h0000});
    frame_start(20'h00400);
    send_status(4'b0010);
    repeat (3) tick();
    cs_n = 1'b1;
    count_req(len);
    check("drain_req_len", len, 6);
    check("drain_busy_after", busy, 0);
    check("drain_rdata_kept", rdata, 16'h1234);
    tick();

    // illegal command
    rq0 = reqs;
    frame_start(20'h00500);
    send_status(4'b0110);
    exp_ec = 1'b1;
    check("cmd_err", {err_cmd, busy, bus_req}, 3'b110);
    repeat (4) tick();
    check("cmd_no_req", reqs, rq0);
    end_frame();

    // late miso_start
    ack_lat = 6;
    rsp_q.push_back(16'h5151);
    exp_q.push_back({1'b0, 20'h00600, 16'h0000});
    frame_start(20'h00600);
    send_status(4'b0010);
    tick();
    pulse_miso();
    exp_el = 1'b1;
    check("late_flag", err_late, 1);
    check("late_rdata_old", rdata, 16'h1234);
    wait_ack("late_ack");
    check("late_rdata_new", rdata, 16'h5151);
    end_frame();

    // random frames
    for (int f = 0; f < 40; f++) begin
      ack_lat = $urandom_range(0, 5);
      base = ADDR_W'($urandom);
      if (f % 8 == 0) base = 20'hFFFFF - ADDR_W'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        inc = 1'($urandom_range(0, 1));
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) begin
          a = inc ? base + ADDR_W'(i) : base;
          exp_q.push_back({1'b0, a, DATA_W'(0)});
        end
        frame_start(base);
        send_status({1'($urandom), 2'b01, inc});
        for (int i = 0; i < n; i++) begin
          wait_ack("rand_rd_ack");
          if (i < n - 1) begin
            repeat ($urandom_range(0, 3)) tick();
            pulse_miso();
          end
        end
      end else begin
        d = DATA_W'($urandom);
        exp_q.push_back({1'b1, base, d});
        frame_start(base);
        send_status({1'($urandom), 2'b10, 1'($urandom)});
        repeat ($urandom_range(0, 3)) tick();
        send_data(d);
        wait_ack("rand_wr_ack");
      end
      repeat ($urandom_range(0, 2)) tick();
      end_frame();
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
